// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - letter codes, message ids and the message ROM for the 7-seg message field
package display_pkg;

    localparam logic [5:0] SEG_0 = 6'h00, SEG_1 = 6'h01, SEG_2 = 6'h02, SEG_3 = 6'h03;
    localparam logic [5:0] SEG_4 = 6'h04, SEG_5 = 6'h05, SEG_6 = 6'h06, SEG_7 = 6'h07;
    localparam logic [5:0] SEG_8 = 6'h08, SEG_9 = 6'h09;
    localparam logic [5:0] SEG_A = 6'h0A, SEG_B = 6'h0B, SEG_C = 6'h0C, SEG_D = 6'h0D;
    localparam logic [5:0] SEG_E = 6'h0E, SEG_F = 6'h0F, SEG_G = 6'h10, SEG_H = 6'h11;
    localparam logic [5:0] SEG_I = 6'h12, SEG_J = 6'h13, SEG_K = 6'h14, SEG_L = 6'h15;
    localparam logic [5:0] SEG_M = 6'h16, SEG_N = 6'h17, SEG_O = 6'h18, SEG_P = 6'h19;
    localparam logic [5:0] SEG_Q = 6'h1A, SEG_R = 6'h1B, SEG_S = 6'h1C, SEG_T = 6'h1D;
    localparam logic [5:0] SEG_U = 6'h1E, SEG_V = 6'h1F, SEG_W = 6'h20, SEG_X = 6'h21;
    localparam logic [5:0] SEG_Y = 6'h22, SEG_Z = 6'h23;
    localparam logic [5:0] SEG_BLANK = 6'h3F;

    typedef enum logic [2:0] {
        MSG_STRT, MSG_PLAY, MSG_WIN, MSG_LOSE, MSG_TIE, MSG_BLJK, MSG_BUST, MSG_DEAL
    } msg_id_t;

    // chars[0] is the first (leftmost) character of the message
    typedef struct packed {
        logic [3:0]      len;
        logic [7:0][5:0] chars;
    } msg_t;

    function automatic msg_t mk_msg(input logic [3:0] len,
                                    input logic [5:0] c0, input logic [5:0] c1,
                                    input logic [5:0] c2, input logic [5:0] c3,
                                    input logic [5:0] c4, input logic [5:0] c5,
                                    input logic [5:0] c6, input logic [5:0] c7);
        msg_t m;
        m.len   = len;
        m.chars = {c7, c6, c5, c4, c3, c2, c1, c0};
        return m;
    endfunction

    function automatic msg_t msg_rom(input msg_id_t id);
        localparam logic [5:0] B = SEG_BLANK;
        msg_t m;
        case (id)
            MSG_STRT: m = mk_msg(4'd4, SEG_S, SEG_T, SEG_R, SEG_T, B, B, B, B);
            MSG_PLAY: m = mk_msg(4'd4, SEG_P, SEG_L, SEG_A, SEG_Y, B, B, B, B);
            MSG_WIN:  m = mk_msg(4'd3, SEG_W, SEG_I, SEG_N, B, B, B, B, B);
            MSG_LOSE: m = mk_msg(4'd4, SEG_L, SEG_O, SEG_S, SEG_E, B, B, B, B);
            MSG_TIE:  m = mk_msg(4'd3, SEG_T, SEG_I, SEG_E, B, B, B, B, B);
            MSG_BLJK: m = mk_msg(4'd4, SEG_B, SEG_L, SEG_J, SEG_K, B, B, B, B);
            MSG_BUST: m = mk_msg(4'd8, SEG_Y, SEG_O, SEG_U, B, SEG_B, SEG_U, SEG_S, SEG_T);
            default:  m = mk_msg(4'd7, SEG_D, SEG_E, SEG_A, SEG_L, SEG_I, SEG_N, SEG_G, B);
        endcase
        return m;
    endfunction

    // Four-character window starting at idx; w[3] is the leftmost digit
    function automatic logic [3:0][5:0] msg_window(input msg_t m, input logic [2:0] idx);
        logic [3:0][5:0] w;
        logic [3:0]      pos;
        for (int i = 0; i < 4; i++) begin
            pos = {1'b0, idx} + 4'(i);
            w[3-i] = (pos < m.len) ? m.chars[pos[2:0]] : SEG_BLANK;
        end
        return w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing a one-cycle display step tick
module tick_prescaler #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/message_sequencer.sv
// rtl/message_sequencer.sv - scroll, blink and hold sequencer for the four-digit message field
module message_sequencer
    import display_pkg::*;
#(
    parameter int TICK_DIV    = 12_500_000,
    parameter int BLINK_COUNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       msg_valid,
    input  logic [2:0] msg_id,
    output logic       msg_ready,
    output logic       busy,
    output logic       done,
    output logic [5:0] letter3,
    output logic [5:0] letter2,
    output logic [5:0] letter1,
    output logic [5:0] letter0
);

    localparam int BW = $clog2(2 * BLINK_COUNT + 1);

    typedef enum logic [1:0] {IDLE, SCROLL, BLINK, HOLD} state_t;

    state_t          state;
    msg_t            msg;
    logic [2:0]      idx;
    logic [BW-1:0]   blink_cnt;
    logic [3:0][5:0] disp;
    logic            tick;
    logic            accept;
    msg_t            new_msg;
    logic [2:0]      idx_next;
    logic [BW-1:0]   blink_next;

    assign accept     = msg_valid && msg_ready;
    assign new_msg    = msg_rom(msg_id_t'(msg_id));
    assign idx_next   = idx + 3'd1;
    assign blink_next = blink_cnt + BW'(1);

    assign letter3 = disp[3];
    assign letter2 = disp[2];
    assign letter1 = disp[1];
    assign letter0 = disp[0];

    // Clearing on accept makes the first step land exactly TICK_DIV cycles later
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            msg       <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            disp      <= {4{SEG_BLANK}};
            msg_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                msg       <= new_msg;
                idx       <= '0;
                blink_cnt <= '0;
                disp      <= msg_window(new_msg, 3'd0);
                state     <= (new_msg.len > 4'd4) ? SCROLL : BLINK;
                msg_ready <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    SCROLL: if (tick) begin
                        idx  <= idx_next;
                        disp <= msg_window(msg, idx_next);
                        if ({1'b0, idx_next} == msg.len - 4'd4) begin
                            state <= BLINK;
                        end
                    end
                    BLINK: if (tick) begin
                        blink_cnt <= blink_next;
                        if (blink_next == BW'(2 * BLINK_COUNT)) begin
                            disp      <= msg_window(msg, idx);
                            state     <= HOLD;
                            msg_ready <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (blink_next[0]) begin
                            disp <= {4{SEG_BLANK}};
                        end else begin
                            disp <= msg_window(msg, idx);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
